// File: rtl/send_moves_if.sv
// send_moves_if: move-pulse inputs and opponent line outputs of the move transmitter
interface send_moves_if;
  logic [2:0] lrp_self;
  logic       my_turn;
  logic       left_data;
  logic       right_data;
  logic       send_data;
  logic       busy;
  logic       overflow;
  modport master (
    output lrp_self, my_turn,
    input  left_data, right_data, send_data, busy, overflow
  );
  modport slave (
    input  lrp_self, my_turn,
    output left_data, right_data, send_data, busy, overflow
  );
endinterface

// File: rtl/send_moves.sv
// send_moves: queues local one-hot moves and replays each as a held level plus an all-low gap
module send_moves #(
  parameter int HOLD_N = 3,
  parameter int GAP_N  = 3,
  parameter int DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  send_moves_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = HOLD_N > GAP_N ? HOLD_N : (GAP_N > 0 ? GAP_N : 1);
  localparam logic [CW-1:0] HOLD_END = CW'((1 << HOLD_N) - 1);
  localparam logic [CW-1:0] GAP_END  = CW'((1 << GAP_N) - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    lines, lines_d, code;
  logic [AW:0]   wr, rd, wr_d, rd_d;
  logic [2:0]    mem [DEPTH];
  logic          empty, full, req, push, pop, ovf, busy_q;
  assign empty = wr == rd;
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign req   = bus.my_turn && |bus.lrp_self;
  assign push  = req && !full;
  assign code  = bus.lrp_self[2] ? 3'b100 : bus.lrp_self[1] ? 3'b010 : 3'b001;
  assign wr_d  = wr + (AW+1)'(push);
  assign rd_d  = rd + (AW+1)'(pop);
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lines_d = lines;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        lines_d = mem[rd[AW-1:0]];
        cnt_d   = '0;
        state_d = DRIVE;
      end
      DRIVE: if (cnt == HOLD_END) begin
        lines_d = '0;
        cnt_d   = '0;
        state_d = GAP;
      end else cnt_d = cnt + CW'(1);
      GAP: if (cnt == GAP_END) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= code;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lines  <= '0;
      wr     <= '0;
      rd     <= '0;
      ovf    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      lines  <= lines_d;
      wr     <= wr_d;
      rd     <= rd_d;
      ovf    <= ovf | (req & full);
      busy_q <= (state_d != IDLE) || (wr_d != rd_d);
    end
  assign bus.left_data  = lines[2];
  assign bus.right_data = lines[1];
  assign bus.send_data  = lines[0];
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_send_moves.sv
// tb_send_moves: directed and random moves checked against a schedule-based model of the link
module tb_send_moves;
  localparam int H = 8, G = 8, D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  send_moves_if bus();
  send_moves #(.HOLD_N(3), .GAP_N(3), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_cmp = 0, n_bad = 0;
  int k = 0, cur = 0, start = -1000, free_at = 0;
  int q[$];
  logic ovf = 1'b0;
  logic [2:0] exp_lines = '0;
  logic exp_busy = 1'b0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // a move may start on any edge at or after free_at; it then owns the lines for H+G cycles
  task automatic model_edge(input logic [2:0] l, input logic m);
    bit was_full = q.size() == D;
    if (q.size() != 0 && k >= free_at) begin
      cur = q.pop_front();
      start = k;
      free_at = k + H + G + 1;
    end
    if (m && l != 0) begin
      if (was_full) ovf = 1'b1;
      else q.push_back(l[2] ? 4 : l[1] ? 2 : 1);
    end
    exp_lines = (k >= start && k < start + H) ? 3'(cur) : 3'b000;
    exp_busy = (k < start + H + G) || q.size() != 0;
    k++;
  endtask
  task automatic step(input logic [2:0] l, input logic m);
    bus.lrp_self = l;
    bus.my_turn = m;
    @(posedge clk);
    model_edge(l, m);
    #1;
    chk("lines", 8'({bus.left_data, bus.right_data, bus.send_data}), 8'(exp_lines));
    chk("busy", 8'(bus.busy), 8'(exp_busy));
    chk("overflow", 8'(bus.overflow), 8'(ovf));
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.lrp_self = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_out", 8'({bus.left_data, bus.right_data, bus.send_data, bus.busy, bus.overflow}), 8'h00);
    q.delete();
    cur = 0; start = -1000; free_at = 0; ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) step(3'b000, m);
  endtask
  initial begin
    bus.lrp_self = '0;
    bus.my_turn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 8'({bus.left_data, bus.right_data, bus.send_data, bus.busy, bus.overflow}), 8'h00);
    rst = 1'b1;
    idle(2, 1'b1);
    step(3'b001, 1'b1);
    idle(20, 1'b1);
    step(3'b100, 1'b1); step(3'b010, 1'b1); step(3'b100, 1'b1);
    idle(60, 1'b1);
    for (int i = 0; i < 6; i++) step(3'(1 << (i % 3)), 1'b1);
    idle(110, 1'b1);
    do_reset();
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b101, 1'b0);
    idle(3, 1'b0);
    step(3'b010, 1'b1); step(3'b001, 1'b1);
    idle(3, 1'b1);
    idle(40, 1'b0);
    step(3'b110, 1'b1);
    idle(20, 1'b1);
    step(3'b100, 1'b1); step(3'b010, 1'b1); step(3'b001, 1'b1); step(3'b000, 1'b1);
    do_reset();
    idle(25, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] l;
      logic m;
      l = ($urandom_range(0, 9) < ((i / 500) % 2 ? 6 : 1)) ? 3'($urandom_range(1, 7)) : 3'b000;
      m = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(l, m);
    end
    idle(120, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
